ts_packet_arbiter: RTL

//  Packet-granular round-robin scheduler that merges NUM_SRC MPEG2-TS byte streams onto one output.

---
 rtl/ts_pkg.sv | 11 +
 rtl/ts_rr_arbiter.sv | 29 ++
 rtl/ts_packet_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// Shared constants and FSM state encoding for the TS packet arbiter.
package ts_pkg;
    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/ts_rr_arbiter.sv
// Combinational rotating-priority picker: the first requester after i_last
// (wrapping modulo NUM_SRC) wins and is returned one-hot and as an index.
module ts_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_SRC);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end
endmodule

// File: rtl/ts_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC TS byte streams with a 2-entry skid buffer.
// Optional `SYNC_CHECK_EN: drop packets whose first byte is not the TS sync byte.
module ts_packet_arbiter
    import ts_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = TS_PKT_LEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_pkt_rdy,
    output logic [NUM_SRC-1:0]            src_rd_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [$clog2(NUM_SRC)-1:0]    out_src,
    output logic [NUM_SRC-1:0]            sync_err
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(PKT_LEN);

    state_t                r_state, w_state_nx;
    logic [NUM_SRC-1:0]    r_grant;
    logic [IDX_W-1:0]      r_gidx, r_last;
    logic [CNT_W-1:0]      r_rd_cnt, r_byte_cnt;
    logic                  r_inflight;
    logic [1:0]            r_sk_cnt;
    logic [DATA_WIDTH-1:0] r_sk0, r_sk1;
    logic                  r_drop;
    logic [NUM_SRC-1:0]    r_sync_err;

    logic [NUM_SRC-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]      w_arb_idx;
    logic [DATA_WIDTH-1:0] w_src_bytes [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_din;
    logic [2:0]            w_occ;
    logic                  w_rd, w_pop, w_push, w_bad, w_drop, w_eop_acc, w_grab;

    ts_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req  (src_pkt_rdy),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign w_src_bytes[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_din     = w_src_bytes[r_gidx];
    assign out_valid = (r_sk_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_eop_acc = w_pop && out_eop;
    assign w_grab    = (r_state == IDLE) && (|src_pkt_rdy);

    // Occupancy the skid will have once this cycle's pop is taken; a read issued now
    // lands two edges later, so it is safe whenever that figure is below two.
    assign w_occ = {1'b0, r_sk_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd  = (r_state == XFER) && (w_occ < 3'd2);

`ifdef SYNC_CHECK_EN
    logic r_first;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first <= 1'b0;
        end else if (w_grab) begin
            r_first <= 1'b1;
        end else if (r_inflight) begin
            r_first <= 1'b0;
        end
    end

    assign w_bad = r_inflight && r_first && (w_din != DATA_WIDTH'(TS_SYNC_BYTE));
`else
    assign w_bad = 1'b0;
`endif

    assign w_drop = r_drop || w_bad;
    assign w_push = r_inflight && !w_drop;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (|src_pkt_rdy) w_state_nx = XFER;
            XFER:    if (w_rd && (r_rd_cnt == CNT_W'(PKT_LEN-1))) w_state_nx = DRAIN;
            DRAIN:   if (w_eop_acc || (r_drop && !r_inflight)) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last     <= IDX_W'(NUM_SRC-1);
            r_rd_cnt   <= '0;
            r_inflight <= 1'b0;
            r_sk_cnt   <= 2'd0;
            r_byte_cnt <= '0;
            r_drop     <= 1'b0;
            r_sync_err <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_inflight <= w_rd;
            r_sync_err <= w_bad ? r_grant : '0;
            if (w_bad) r_drop <= 1'b1;
            if (w_rd)  r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_grab) begin
                r_grant  <= w_arb_gnt;
                r_gidx   <= w_arb_idx;
                r_last   <= w_arb_idx;
                r_rd_cnt <= '0;
                r_drop   <= 1'b0;
            end else if ((r_state == DRAIN) && (w_state_nx == IDLE)) begin
                r_grant  <= '0;
            end
            case ({w_push, w_pop})
                2'b10:   r_sk_cnt <= r_sk_cnt + 2'd1;
                2'b01:   r_sk_cnt <= r_sk_cnt - 2'd1;
                default: r_sk_cnt <= r_sk_cnt;
            endcase
            if (w_pop) begin
                r_byte_cnt <= (r_byte_cnt == CNT_W'(PKT_LEN-1)) ? '0 : r_byte_cnt + 1'b1;
            end
        end
    end

    // Skid storage: r_sk0 is always the head; contents are qualified by r_sk_cnt.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if ((r_sk_cnt == 2'd0) || ((r_sk_cnt == 2'd1) && w_pop)) begin
                r_sk0 <= w_din;
            end else if (r_sk_cnt == 2'd1) begin
                r_sk1 <= w_din;
            end else begin
                r_sk0 <= r_sk1;
                r_sk1 <= w_din;
            end
        end else if (w_pop) begin
            r_sk0 <= r_sk1;
        end
    end

    assign src_rd_en = w_rd ? r_grant : '0;
    assign grant     = r_grant;
    assign busy      = (r_state != IDLE);
    assign out_data  = out_valid ? r_sk0 : '0;
    assign out_sop   = out_valid && (r_byte_cnt == '0);
    assign out_eop   = out_valid && (r_byte_cnt == CNT_W'(PKT_LEN-1));
    assign out_src   = out_valid ? r_gidx : '0;
    assign sync_err  = r_sync_err;
endmodule
